// File: rtl/video_timing_detect.sv
// Video timing detector: measures H/V sync, porch, active and total sizes from an HS/VS/DE
// stream and flags lock once LOCK_FRAMES consecutive frames measure identically.
module video_timing_detect #(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic        I_pxl_clk,
    input  logic        I_rst_n,
    input  logic        I_hs,
    input  logic        I_vs,
    input  logic        I_de,
    input  logic        I_hs_pol,
    input  logic        I_vs_pol,
    output logic [15:0] O_h_total,
    output logic [15:0] O_h_sync,
    output logic [15:0] O_h_bporch,
    output logic [15:0] O_h_res,
    output logic [15:0] O_v_total,
    output logic [15:0] O_v_sync,
    output logic [15:0] O_v_bporch,
    output logic [15:0] O_v_res,
    output logic        O_locked,
    output logic        O_fmt_change
);
    localparam logic [3:0]  LockN  = 4'(LOCK_FRAMES);
    localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);
    localparam logic [15:0] ToMax  = 16'(TIMEOUT);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] sub_clamp(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? a - b : 16'd0;
    endfunction

    logic hs_r, vs_r, de_r, hs_h, vs_h, de_h;
    logic [1:0] prime_q;
    logic hs_a, vs_a, ok;
    logic hs_rise, hs_fall, vs_rise, vs_fall, de_rise, de_fall;
    logic first_de_line, first_de_frame, timeout, frame_done;

    // Shadow / output / previous-frame vectors; index order: h_total, h_sync, h_bporch,
    // h_res, v_total, v_sync, v_bporch, v_res.
    logic [7:0][15:0] sh_q, sh_d, out_q, prev_q;
    logic [15:0] hcnt_q, hcnt_d, hpos, vcnt_q, vcnt_d, vpos;
    logic [15:0] de_run_q, de_run_d, vres_q, vres_d, to_q, to_d;
    logic line_de_q, line_de_d, frame_de_q, frame_de_d;
    logic armed_q, armed_d, have_prev_q, have_prev_d, locked_q, locked_d, fmt_q, fmt_d;
    logic [3:0] match_q, match_d;

    assign hs_a = (hs_r == I_hs_pol);
    assign vs_a = (vs_r == I_vs_pol);
    // History is only meaningful two clocks after reset; earlier edges are artefacts of
    // the reset value meeting an active-low polarity.
    assign ok      = prime_q[1];
    assign hs_rise = ok & hs_a & ~hs_h;
    assign hs_fall = ok & ~hs_a & hs_h;
    assign vs_rise = ok & vs_a & ~vs_h;
    assign vs_fall = ok & ~vs_a & vs_h;
    assign de_rise = ok & de_r & ~de_h;
    assign de_fall = ok & ~de_r & de_h;

    assign first_de_line  = de_rise & (hs_rise | ~line_de_q);
    assign first_de_frame = de_rise & (vs_rise | ~frame_de_q);
    assign timeout        = ~hs_rise & (to_q == ToLast);
    assign frame_done     = vs_rise & armed_q & ~timeout;
    assign hpos           = sat_inc(hcnt_q);
    assign vpos           = hs_rise ? sat_inc(vcnt_q) : vcnt_q;

    always_comb begin
        sh_d        = sh_q;
        hcnt_d      = hs_rise ? 16'd0 : hpos;
        vcnt_d      = vs_rise ? 16'd0 : vpos;
        de_run_d    = de_rise ? 16'd1 : (de_r ? sat_inc(de_run_q) : de_run_q);
        line_de_d   = hs_rise ? de_rise : (line_de_q | de_rise);
        frame_de_d  = vs_rise ? de_rise : (frame_de_q | de_rise);
        vres_d      = vres_q;
        to_d        = hs_rise ? 16'd0 : ((to_q != ToMax) ? to_q + 16'd1 : to_q);
        armed_d     = armed_q;
        have_prev_d = have_prev_q;
        match_d     = match_q;
        fmt_d       = 1'b0;

        if (hs_rise) sh_d[0] = hpos;
        if (hs_fall) sh_d[1] = hpos;
        if (first_de_line) sh_d[2] = sub_clamp(hpos, sh_d[1]);
        if (de_fall) sh_d[3] = de_run_q;
        if (vs_rise) begin
            sh_d[4] = sat_inc(vcnt_q);
            sh_d[7] = vres_q;
        end
        if (vs_fall) sh_d[5] = vpos;
        if (first_de_frame) sh_d[6] = sub_clamp(vpos, sh_d[5]);

        if (vs_rise) begin
            vres_d = first_de_line ? 16'd1 : 16'd0;
        end else if (first_de_line) begin
            vres_d = sat_inc(vres_q);
        end

        if (timeout) begin
            armed_d     = 1'b0;
            have_prev_d = 1'b0;
            match_d     = 4'd0;
        end else if (vs_rise) begin
            armed_d = 1'b1;
            if (armed_q) begin
                have_prev_d = 1'b1;
                if (have_prev_q) begin
                    if (sh_d == prev_q) begin
                        if (match_q < LockN) match_d = match_q + 4'd1;
                    end else begin
                        match_d = 4'd0;
                        fmt_d   = 1'b1;
                    end
                end
            end
        end
        locked_d = (match_d == LockN);
    end

    always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            {hs_r, vs_r, de_r, hs_h, vs_h, de_h} <= '0;
            prime_q     <= '0;
            sh_q        <= '0;
            out_q       <= '0;
            prev_q      <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            de_run_q    <= '0;
            vres_q      <= '0;
            to_q        <= '0;
            line_de_q   <= 1'b0;
            frame_de_q  <= 1'b0;
            armed_q     <= 1'b0;
            have_prev_q <= 1'b0;
            match_q     <= '0;
            locked_q    <= 1'b0;
            fmt_q       <= 1'b0;
        end else begin
            hs_r        <= I_hs;
            vs_r        <= I_vs;
            de_r        <= I_de;
            hs_h        <= hs_a;
            vs_h        <= vs_a;
            de_h        <= de_r;
            prime_q     <= {prime_q[0], 1'b1};
            sh_q        <= sh_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            de_run_q    <= de_run_d;
            vres_q      <= vres_d;
            to_q        <= to_d;
            line_de_q   <= line_de_d;
            frame_de_q  <= frame_de_d;
            armed_q     <= armed_d;
            have_prev_q <= have_prev_d;
            match_q     <= match_d;
            locked_q    <= locked_d;
            fmt_q       <= fmt_d;
            if (frame_done) begin
                out_q  <= sh_d;
                prev_q <= sh_d;
            end
        end
    end

    assign O_h_total    = out_q[0];
    assign O_h_sync     = out_q[1];
    assign O_h_bporch   = out_q[2];
    assign O_h_res      = out_q[3];
    assign O_v_total    = out_q[4];
    assign O_v_sync     = out_q[5];
    assign O_v_bporch   = out_q[6];
    assign O_v_res      = out_q[7];
    assign O_locked     = locked_q;
    assign O_fmt_change = fmt_q;
endmodule

// File: tb/tb_video_timing_detect.sv
// Scoreboard bench for video_timing_detect using scaled-down video formats so that every
// scenario (lock, format switch, short DE, timeout, reset, inverted sync) fits in a short run.
module tb_video_timing_detect;
    localparam int LOCK = 2;
    localparam int TO   = 300;

    typedef struct {
        int ht, hs, hb, hr, vt, vs, vb, vr;
    } fmt_t;
    typedef logic [7:0][15:0] vals_t;
    typedef struct packed {
        vals_t v;
        logic  locked;
        logic  pulse;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, i_hs, i_vs, i_de, hs_pol, vs_pol;
    logic [15:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
    logic locked, fmt_change;
    vals_t dut_v;

    exp_t  exp_q[$];
    vals_t m_out, m_prev, last_fv;
    bit    m_armed, m_have_prev;
    int    m_match;
    logic  m_locked;
    logic  vs_mark, d1, fire;
    int    n_cmp = 0, n_bad = 0;
    fmt_t  fa, fb;
    string nm[8] = '{"h_total", "h_sync", "h_bporch", "h_res",
                     "v_total", "v_sync", "v_bporch", "v_res"};

    video_timing_detect #(.LOCK_FRAMES(LOCK), .TIMEOUT(TO)) dut (
        .I_pxl_clk(clk), .I_rst_n(rst_n), .I_hs(i_hs), .I_vs(i_vs), .I_de(i_de),
        .I_hs_pol(hs_pol), .I_vs_pol(vs_pol),
        .O_h_total(h_total), .O_h_sync(h_sync), .O_h_bporch(h_bporch), .O_h_res(h_res),
        .O_v_total(v_total), .O_v_sync(v_sync), .O_v_bporch(v_bporch), .O_v_res(v_res),
        .O_locked(locked), .O_fmt_change(fmt_change)
    );

    assign dut_v = {v_res, v_bporch, v_sync, v_total, h_res, h_bporch, h_sync, h_total};

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        assert (got === want)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_all(input string ctx, input exp_t e);
        for (int i = 0; i < 8; i++) chk({ctx, ".", nm[i]}, dut_v[i], e.v[i]);
        chk({ctx, ".locked"}, 16'(locked), 16'(e.locked));
        chk({ctx, ".fmt_change"}, 16'(fmt_change), 16'(e.pulse));
    endtask

    function automatic vals_t frame_vals(input fmt_t f, input bit short_de);
        vals_t v;
        v[0] = 16'(f.ht); v[1] = 16'(f.hs); v[2] = 16'(f.hb);
        v[3] = 16'(short_de ? f.hr - 1 : f.hr);
        v[4] = 16'(f.vt); v[5] = 16'(f.vs); v[6] = 16'(f.vb); v[7] = 16'(f.vr);
        return v;
    endfunction

    // Frame-level reference: what the outputs must show two clocks after each VS.
    task automatic model_vs();
        exp_t e;
        e.pulse = 1'b0;
        if (!m_armed) begin
            m_armed = 1'b1;
        end else begin
            if (m_have_prev) begin
                if (last_fv == m_prev) begin
                    if (m_match < LOCK) m_match++;
                end else begin
                    m_match = 0;
                    e.pulse = 1'b1;
                end
            end
            m_have_prev = 1'b1;
            m_prev = last_fv;
            m_out  = last_fv;
        end
        m_locked = (m_match == LOCK);
        e.v = m_out;
        e.locked = m_locked;
        exp_q.push_back(e);
    endtask

    task automatic model_drop(input bit full_reset);
        m_armed = 1'b0; m_have_prev = 1'b0; m_match = 0; m_locked = 1'b0;
        if (full_reset) begin
            m_out = '0; m_prev = '0;
        end
    endtask

    task automatic drive_px(input logic ah, input logic av, input logic de, input logic mark);
        @(negedge clk);
        i_hs = ah ~^ hs_pol;
        i_vs = av ~^ vs_pol;
        i_de = de;
        vs_mark = mark;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_px(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic gen_frame(input fmt_t f, input bit short_de, input int l0, input int l1);
        int a0, a1, p0, p1;
        a0 = f.vs + f.vb; a1 = a0 + f.vr;
        p0 = f.hs + f.hb; p1 = p0 + f.hr;
        for (int l = l0; l < l1; l++) begin
            for (int p = 0; p < f.ht; p++) begin
                logic first, de;
                first = (l == 0) && (p == 0);
                de = (l >= a0) && (l < a1) && (p >= p0) && (p < p1);
                if (short_de && l == a1 - 1 && p == p1 - 1) de = 1'b0;
                if (first) model_vs();
                drive_px(p < f.hs, l < f.vs, de, first);
            end
        end
        if (l1 == f.vt) last_fv = frame_vals(f, short_de);
    endtask

    task automatic frames(input fmt_t f, input int n);
        for (int i = 0; i < n; i++) gen_frame(f, 1'b0, 0, f.vt);
    endtask

    // Monitor: the frame marker driven with the VS pixel lands on the outputs two edges later.
    initial begin
        exp_t e;
        d1 = 1'b0;
        forever begin
            @(posedge clk);
            fire = d1;
            d1 = vs_mark;
            #1;
            if (fire) begin
                chk("sb_pending", 16'(exp_q.size() != 0), 16'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_all("vs", e);
                end
            end else begin
                chk("no_stray_pulse", 16'(fmt_change), 16'd0);
            end
        end
    end

    initial begin
        exp_t z;
        fa = '{ht: 40, hs: 4, hb: 6, hr: 24, vt: 12, vs: 2, vb: 3, vr: 6};
        fb = '{ht: 50, hs: 5, hb: 8, hr: 30, vt: 15, vs: 3, vb: 2, vr: 8};
        z = '0;
        rst_n = 1'b0; hs_pol = 1'b1; vs_pol = 1'b1;
        i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b0; vs_mark = 1'b0;
        model_drop(1'b1);
        repeat (3) @(negedge clk);
        #1 check_all("reset", z);
        rst_n = 1'b1;
        idle(10);

        // Lock on format A: arm, publish, match, lock, stay locked.
        frames(fa, 5);
        // Switch to B: one pulse at the first mismatching VS, relock two frames later.
        frames(fb, 4);
        // Shortened DE on the last active line, then normal frames until relock.
        gen_frame(fb, 1'b1, 0, fb.vt);
        frames(fb, 4);

        // Stream stops: lock holds until the timeout expires, then drops with outputs held.
        idle(100);
        #1 chk("pre_timeout.locked", 16'(locked), 16'(m_locked));
        idle(300);
        model_drop(1'b0);
        z.v = m_out; z.locked = 1'b0; z.pulse = 1'b0;
        #1 check_all("timeout", z);

        // Resume: one arming VS plus three frames to relock.
        frames(fa, 5);

        // Reset mid-frame while locked; the remainder of that frame must not count.
        gen_frame(fa, 1'b0, 0, 6);
        @(negedge clk);
        rst_n = 1'b0;
        model_drop(1'b1);
        #1 check_all("mid_reset", '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        gen_frame(fa, 1'b0, 6, fa.vt);
        frames(fa, 5);

        // Active-low syncs with inverted stream must measure and lock identically.
        @(negedge clk);
        rst_n = 1'b0;
        model_drop(1'b1);
        hs_pol = 1'b0; vs_pol = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(5);
        frames(fa, 5);

        idle(5);
        chk("sb_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/video_timing_detect.md
VIDEO_TIMING_DETECT -- requirements
Module: video_timing_detect

Interface
REQ-001 Parameter LOCK_FRAMES, default 2: consecutive identical complete frames required before lock asserts; legal range 1..15.
REQ-002 Parameter TIMEOUT, default 65535: pixel clocks without an HS active edge before lock is dropped.
REQ-003 I_pxl_clk  in  1  pixel clock; the only clock, all logic on its rising edge.
REQ-004 I_rst_n  in  1  asynchronous, active-low reset.
REQ-005 I_hs, I_vs, I_de  in  1 each  incoming sync and data-enable stream.
REQ-006 I_hs_pol, I_vs_pol  in  1 each  sync polarity; 1 = HS/VS active-high, 0 = active-low.
REQ-007 O_h_total, O_h_sync, O_h_bporch, O_h_res  out  16 each  measured horizontal timing, in pixel clocks.
REQ-008 O_v_total, O_v_sync, O_v_bporch, O_v_res  out  16 each  measured vertical timing, in lines.
REQ-009 O_locked  out  1  timing stable for LOCK_FRAMES frames.
REQ-010 O_fmt_change  out  1  one-clock pulse on any frame-to-frame measurement mismatch.

Function
REQ-011 I_hs, I_vs and I_de shall be registered once; hs_a = (registered HS == I_hs_pol) and vs_a = (registered VS == I_vs_pol); all edges are detected on these registered, normalised signals.
REQ-012 hcnt shall be cleared to 0 on the HS rising-edge cycle and shall otherwise increment, saturating at 16'hFFFF.
REQ-013 Horizontal shadow values: on the HS rising edge, total = hcnt+1; on the HS falling edge, sync = hcnt; on the first DE rising edge in a line, bporch = hcnt - sync; on the DE falling edge, res = the DE-high run length (separate counter, saturating).
REQ-014 vcnt shall increment on each HS rising edge and clear to 0 on the VS rising edge; VS rising takes priority when both occur in the same cycle.
REQ-015 Vertical shadow values: on the VS rising edge, total = vcnt+1; on the VS falling edge, sync = vcnt; on the first DE rising edge in a frame, bporch = vcnt - sync; res = count of lines with a DE rising edge in the frame.
REQ-016 A frame is complete at each VS rising edge that has a previous VS rising edge since reset or timeout; the first VS rising edge only arms measurement.
REQ-017 On frame completion, the 8 shadow values shall be transferred to the O_* outputs; this update is visible 2 clocks after I_vs goes active at the port, and outputs hold between updates.
REQ-018 On frame completion, shadow values shall be compared with the previous complete frame: equal -> match_cnt increments (saturating at LOCK_FRAMES); unequal -> match_cnt = 0, O_locked = 0 and O_fmt_change pulses for exactly 1 clock.
REQ-019 O_locked shall assert in the same cycle match_cnt reaches LOCK_FRAMES.
REQ-020 The first complete frame has no predecessor and shall produce neither a match nor a pulse.
REQ-021 If TIMEOUT clocks elapse with no HS rising edge: O_locked = 0, match_cnt = 0, measurement disarmed (REQ-016), O_* outputs hold, no O_fmt_change pulse.
REQ-022 A change of I_hs_pol or I_vs_pol shall be treated as ordinary input; any resulting mismatch is handled by REQ-018.
REQ-023 Subtractions that would go negative (DE before sync end) shall clamp to 0.

Reset
REQ-024 While I_rst_n = 0, all O_* values, O_locked, O_fmt_change, counters, shadow registers and edge-detect history shall be 0 and measurement shall be disarmed.
REQ-025 Reset deassertion mid-frame shall require a fresh VS rising edge to arm measurement, with no partial-frame results published.

Verification
REQ-026 800x600 stream (h 1056/128/88/800, v 628/4/23/600, pol 1/1) -> after the 2nd VS the outputs equal those values; O_locked = 1 at the 4th VS, with no O_fmt_change pulse.
REQ-027 Same stream with I_hs_pol = I_vs_pol = 0 and the syncs inverted -> identical outputs and lock timing.
REQ-028 Locked stream switched to 1280x720 (1650/40/220/1280, 750/5/20/720) -> O_fmt_change pulses once and O_locked falls at the first mismatching VS; relock 2 frames later with the new values.
REQ-029 HS/VS held inactive for 65535 clocks while locked -> O_locked = 0, outputs hold, no pulse; after the stream resumes, 1 arming VS plus 3 frames are needed to relock.
REQ-030 I_rst_n pulsed low mid-frame while locked -> all outputs 0 immediately; the partial frame is ignored and lock returns at the 4th subsequent VS.
REQ-031 One line with DE shortened to 799 -> h_res mismatch -> one O_fmt_change pulse, O_locked = 0, and match_cnt restarts.
